// File: rtl/mc_controller_pkg.sv
// Shared encodings for the multicycle MIPS control unit: FSM states, opcodes,
// funct fields, ALU-op classes and ALU control codes, plus per-state decode.
package mc_controller_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef struct packed {
    logic       pcwrite;
    logic       branch;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic       alusrca;
    logic       iord;
    logic       memtoreg;
    logic       regdst;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
  } ctrl_t;

  // Moore output decode; unknown state codes fall through to all-zero.
  function automatic ctrl_t state_ctrl(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.alusrcb = 2'b01;
        c.irwrite = 1'b1;
        c.pcwrite = 1'b1;
      end
      S_DECODE:  c.alusrcb = 2'b11;
      S_MEMADR: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
      end
      S_MEMRD:   c.iord = 1'b1;
      S_MEMWB: begin
        c.memtoreg = 1'b1;
        c.regwrite = 1'b1;
      end
      S_MEMWR: begin
        c.iord     = 1'b1;
        c.memwrite = 1'b1;
      end
      S_RTYPEEX: begin
        c.alusrca = 1'b1;
        c.aluop   = ALUOP_FUNCT;
      end
      S_RTYPEWB: begin
        c.regdst   = 1'b1;
        c.regwrite = 1'b1;
      end
      S_BEQEX: begin
        c.alusrca = 1'b1;
        c.aluop   = ALUOP_SUB;
        c.pcsrc   = 2'b01;
        c.branch  = 1'b1;
      end
      S_ADDIEX: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
      end
      S_ADDIWB:  c.regwrite = 1'b1;
      S_JEX: begin
        c.pcsrc   = 2'b10;
        c.pcwrite = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mc_controller_aludec.sv
// Combinational ALU decoder: maps the FSM's aluop class and the R-type funct
// field onto the 3-bit ALU control code.
module mc_controller_aludec
  import mc_controller_pkg::*;
(
  input  logic [1:0] aluop_i,
  input  logic [5:0] funct_i,
  output logic [2:0] alucontrol_o
);

  always_comb begin
    alucontrol_o = ALU_ADD;
    case (aluop_i)
      ALUOP_ADD: alucontrol_o = ALU_ADD;
      ALUOP_SUB: alucontrol_o = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct_i)
          FN_ADD:  alucontrol_o = ALU_ADD;
          FN_SUB:  alucontrol_o = ALU_SUB;
          FN_AND:  alucontrol_o = ALU_AND;
          FN_OR:   alucontrol_o = ALU_OR;
          FN_SLT:  alucontrol_o = ALU_SLT;
          default: alucontrol_o = ALU_ADD;
        endcase
      end
      default: alucontrol_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS control FSM. Moore outputs are registered alongside the state;
// only pcen depends combinationally on zero, and all write strobes are masked by reset.
module mc_controller
  import mc_controller_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pcen,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic       alusrca,
  output logic       iord,
  output logic       memtoreg,
  output logic       regdst,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol
);

  state_t state_q, state_d;
  ctrl_t  ctrl_q;

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_RTYPEEX;
          OP_BEQ:       state_d = S_BEQEX;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JEX;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        if (op == OP_LW)      state_d = S_MEMRD;
        else if (op == OP_SW) state_d = S_MEMWR;
        else                  state_d = S_FETCH;
      end
      S_MEMRD:   state_d = S_MEMWB;
      S_RTYPEEX: state_d = S_RTYPEWB;
      S_ADDIEX:  state_d = S_ADDIWB;
      default:   state_d = S_FETCH;
    endcase
  end

  // Outputs are decoded from the next state so they line up with state_q.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      ctrl_q  <= state_ctrl(S_FETCH);
    end else begin
      state_q <= state_d;
      ctrl_q  <= state_ctrl(state_d);
    end
  end

  mc_controller_aludec u_aludec (
    .aluop_i      (ctrl_q.aluop),
    .funct_i      (funct),
    .alucontrol_o (alucontrol)
  );

  assign pcen     = ~reset & (ctrl_q.pcwrite | (ctrl_q.branch & zero));
  assign memwrite = ~reset & ctrl_q.memwrite;
  assign irwrite  = ~reset & ctrl_q.irwrite;
  assign regwrite = ~reset & ctrl_q.regwrite;
  assign alusrca  = ctrl_q.alusrca;
  assign iord     = ctrl_q.iord;
  assign memtoreg = ctrl_q.memtoreg;
  assign regdst   = ctrl_q.regdst;
  assign alusrcb  = ctrl_q.alusrcb;
  assign pcsrc    = ctrl_q.pcsrc;

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: per-instruction expected output cycles are
// queued by the stimulus and compared each cycle by an independent monitor.
module tb_mc_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op, funct;
  logic       zero;
  logic       pcen, memwrite, irwrite, regwrite, alusrca, iord, memtoreg, regdst;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;

  mc_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .pcen(pcen), .memwrite(memwrite), .irwrite(irwrite), .regwrite(regwrite),
    .alusrca(alusrca), .iord(iord), .memtoreg(memtoreg), .regdst(regdst),
    .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol)
  );

  always #5 clk = ~clk;

  // Vector layout: pcen memwrite irwrite regwrite alusrca iord memtoreg regdst alusrcb pcsrc alucontrol
  localparam logic [14:0] ALL     = 15'h7fff;
  localparam logic [14:0] STROBES = 15'h7800;

  typedef struct {
    logic [14:0] v;
    logic [14:0] m;
    logic [5:0]  op;
    int          idx;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   fails  = 0;

  function automatic logic [14:0] ev(input bit pc, mw, irw, rw, asa, io, m2r, rd,
                                     input bit [1:0] asb, ps, input bit [2:0] ac);
    return {pc, mw, irw, rw, asa, io, m2r, rd, asb, ps, ac};
  endfunction

  function automatic logic [2:0] alu_ref(input logic [5:0] f);
    case (f)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  // Reference: the cycle-by-cycle output vectors an instruction should produce.
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                           input int rst_at);
    logic [14:0] plan[$];
    exp_t e;
    plan.push_back(ev(1,0,1,0,0,0,0,0,2'b01,2'b00,3'b010));
    plan.push_back(ev(0,0,0,0,0,0,0,0,2'b11,2'b00,3'b010));
    case (o)
      6'b100011: begin
        plan.push_back(ev(0,0,0,0,1,0,0,0,2'b10,2'b00,3'b010));
        plan.push_back(ev(0,0,0,0,0,1,0,0,2'b00,2'b00,3'b010));
        plan.push_back(ev(0,0,0,1,0,0,1,0,2'b00,2'b00,3'b010));
      end
      6'b101011: begin
        plan.push_back(ev(0,0,0,0,1,0,0,0,2'b10,2'b00,3'b010));
        plan.push_back(ev(0,1,0,0,0,1,0,0,2'b00,2'b00,3'b010));
      end
      6'b000000: begin
        plan.push_back(ev(0,0,0,0,1,0,0,0,2'b00,2'b00,alu_ref(f)));
        plan.push_back(ev(0,0,0,1,0,0,0,1,2'b00,2'b00,3'b010));
      end
      6'b000100: plan.push_back(ev(z,0,0,0,1,0,0,0,2'b00,2'b01,3'b110));
      6'b001000: begin
        plan.push_back(ev(0,0,0,0,1,0,0,0,2'b10,2'b00,3'b010));
        plan.push_back(ev(0,0,0,1,0,0,0,0,2'b00,2'b00,3'b010));
      end
      6'b000010: plan.push_back(ev(1,0,0,0,0,0,0,0,2'b00,2'b10,3'b010));
      default: ;
    endcase
    op = o; funct = f; zero = z;
    for (int i = 0; i < plan.size(); i++) begin
      if (rst_at >= 0 && i > rst_at) break;
      e.v = plan[i];
      e.m = ALL;
      e.op = o;
      e.idx = i;
      if (i == rst_at) begin
        e.v = plan[i] & ~STROBES;
        e.m = (plan[i] == plan[i]) ? ALL : ALL; // Moore fields still hold, strobes forced low
      end
      sb.push_back(e);
      reset = (i == rst_at);
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
  endtask

  // Monitor: one comparison per cycle, sampled on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    logic [14:0] act;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      act = {pcen, memwrite, irwrite, regwrite, alusrca, iord, memtoreg, regdst,
             alusrcb, pcsrc, alucontrol};
      checks++;
      if ((act & e.m) !== (e.v & e.m)) begin
        fails++;
        $display("FAIL op=%b cyc%0d: got %b want %b (mask %b)", e.op, e.idx, act, e.v, e.m);
      end
    end
  end

  initial begin
    exp_t e;
    logic [5:0] defs[6];
    logic [5:0] fns[5];
    logic [5:0] o, f;
    int n, ra;
    defs = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
    fns  = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    reset = 1'b1; op = 6'b000000; funct = 6'b000000; zero = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      e.v = '0; e.m = STROBES; e.op = op; e.idx = -1;
      sb.push_back(e);
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    run_instr(6'b100011, 6'h00, 1'b0, -1);
    run_instr(6'b101011, 6'h00, 1'b1, -1);
    for (int i = 0; i < 5; i++) run_instr(6'b000000, fns[4 - i], 1'b0, -1);
    run_instr(6'b000000, 6'b111111, 1'b0, -1);
    run_instr(6'b000100, 6'h00, 1'b1, -1);
    run_instr(6'b000100, 6'h00, 1'b0, -1);
    run_instr(6'b000010, 6'h00, 1'b0, -1);
    run_instr(6'b111111, 6'h00, 1'b1, -1);
    run_instr(6'b100011, 6'h00, 1'b0, 3);
    run_instr(6'b101011, 6'h00, 1'b0, 3);
    run_instr(6'b001000, 6'h00, 1'b1, -1);

    for (int k = 0; k < 80; k++) begin
      o = ($urandom_range(3) != 0) ? defs[$urandom_range(5)] : 6'($urandom_range(63));
      f = ($urandom_range(3) != 0) ? fns[$urandom_range(4)] : 6'($urandom_range(63));
      ra = -1;
      if ($urandom_range(7) == 0) ra = int'($urandom_range(4));
      run_instr(o, f, 1'($urandom_range(1)), ra);
    end

    n = 0;
    while (sb.size() > 0 && n < 10) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() > 0) begin
      checks++;
      fails++;
      $display("FAIL drain: %0d entries left, want 0", sb.size());
    end
    #20;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
- Multicycle MIPS control unit: the control-side counterpart of the multicycle datapath.
- Consumes op, funct and zero from the datapath; drives every datapath enable and mux select plus the memory write strobe.
- Moore FSM sequencing fetch, decode, execute, memory and writeback, with a combinational ALU decoder.
- Supports lw, sw, R-type (add/sub/and/or/slt), beq, addi and j.

Parameters:
- None. All encodings are fixed in the shared package.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high reset
- op  input  6  instr[31:26] from the datapath
- funct  input  6  instr[5:0] from the datapath
- zero  input  1  ALU zero flag
- pcen  output  1  PC register enable
- memwrite  output  1  memory write strobe
- irwrite  output  1  instruction register enable
- regwrite  output  1  register file write enable
- alusrca  output  1  ALU A source: 0 = pc, 1 = A register
- iord  output  1  address source: 0 = pc, 1 = aluout
- memtoreg  output  1  register write data: 1 = memory data register
- regdst  output  1  write register: 0 = rt, 1 = rd
- alusrcb  output  2  ALU B source: 00 = B, 01 = 4, 10 = signimm, 11 = signimm<<2
- pcsrc  output  2  next PC: 00 = aluresult, 01 = aluout, 10 = jump target
- alucontrol  output  3  ALU operation: 010 add, 110 sub, 000 and, 001 or, 111 slt

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high. Reset loads state FETCH.
- Outputs during reset: while reset is high, pcen, irwrite, regwrite and memwrite are forced to 0.
- State encoding (4 bits): FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPEEX=6, RTYPEWB=7, BEQEX=8, ADDIEX=9, ADDIWB=10, JEX=11.
- Outputs are a pure function of state (Moore), except pcen = pcwrite | (branch & zero). pcen is combinational on zero.
- Default value of every unlisted output in a state is 0.
- Per-state outputs:
  - FETCH: iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00, irwrite=1, pcwrite=1. Next: DECODE.
  - DECODE: alusrca=0, alusrcb=11, aluop=00. Next by op: 100011/101011 -> MEMADR; 000000 -> RTYPEEX; 000100 -> BEQEX; 001000 -> ADDIEX; 000010 -> JEX; any other op -> FETCH (treated as a nop, no side effects).
  - MEMADR: alusrca=1, alusrcb=10, aluop=00. Next: MEMRD if op=100011, MEMWR if op=101011.
  - MEMRD: iord=1. Next: MEMWB.
  - MEMWB: regdst=0, memtoreg=1, regwrite=1. Next: FETCH.
  - MEMWR: iord=1, memwrite=1. Next: FETCH.
  - RTYPEEX: alusrca=1, alusrcb=00, aluop=10. Next: RTYPEWB.
  - RTYPEWB: regdst=1, memtoreg=0, regwrite=1. Next: FETCH.
  - BEQEX: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch=1. Next: FETCH.
  - ADDIEX: alusrca=1, alusrcb=10, aluop=00. Next: ADDIWB.
  - ADDIWB: regdst=0, memtoreg=0, regwrite=1. Next: FETCH.
  - JEX: pcsrc=10, pcwrite=1. Next: FETCH.
- ALU decode:
  - aluop 00 -> 010 (add); aluop 01 -> 110 (sub).
  - aluop 10 by funct: 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111, any other funct -> 010.
  - aluop 11 is never generated; it decodes to 010.
- Cycles per instruction, FETCH inclusive: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
- Illegal state codes 12-15 -> next state FETCH, outputs all 0.
- Reset in any state -> FETCH on the next edge. A partially completed instruction is abandoned; no write strobe may assert in the cycle reset is high.
- op and funct are sampled only in DECODE, MEMADR and RTYPEEX. They are assumed stable because irwrite=0 outside FETCH.

Decomposition:
- Shared package holds:
  - state localparams
  - opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J
  - funct constants
  - aluop codes
  - alucontrol codes
- One sub-module, aludec: inputs aluop[1:0] and funct[5:0], output alucontrol[2:0], purely combinational.
- The FSM (state register, next-state logic, output decode) stays in mc_controller.

Test Plan:
- Reset held 2 cycles, then released with op=000000 -> pcen, irwrite, regwrite and memwrite are 0 during reset. First cycle after release shows FETCH: irwrite=1, pcen=1, alusrcb=01, alucontrol=010.
- lw (op=100011) -> state sequence 0,1,2,3,4,0. MEMRD has iord=1. MEMWB has regwrite=1, memtoreg=1, regdst=0. memwrite stays 0 throughout.
- sw (op=101011) -> 0,1,2,5,0. memwrite=1 with iord=1 for exactly one cycle. regwrite is never 1.
- R-type with funct=101010 -> RTYPEEX alucontrol=111, alusrca=1, alusrcb=00. RTYPEWB has regwrite=1, regdst=1. Repeat for funct 100000/100010/100100/100101, expecting 010/110/000/001.
- beq (op=000100) -> BEQEX alucontrol=110, pcsrc=01. With zero=1, pcen=1; with zero=0, pcen=0. Next state is FETCH in both cases.
- j (op=000010), then undefined op=111111 -> JEX pcsrc=10, pcen=1, 3 cycles total. The undefined op returns DECODE -> FETCH with no write enables asserted. Asserting reset in MEMRD yields FETCH next with no MEMWB.
